wrr_cfg_master: RTL and testbench

WRR_CFG_MASTER -- requirements
Module: wrr_cfg_master

---
 rtl/wrr_cfg_pkg.sv | 33 +++
 rtl/wrr_cfg_master.sv | 173 +++++++++++++++++
 tb/tb_wrr_cfg_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_cfg_pkg.sv
// Shared types for the WRR config master: FSM states, response error codes, readback layout.
// VFY states exist only when WRR_CFG_VERIFY_EN is defined.
package wrr_cfg_pkg;

  localparam int unsigned WDATA_W = 9;
  localparam int unsigned RDBK_W  = 27;

  // Readback word layout {round, cfg_weight, counter}
  localparam int unsigned ROUND_MSB  = 26;
  localparam int unsigned ROUND_LSB  = 16;
  localparam int unsigned WEIGHT_MSB = 15;
  localparam int unsigned WEIGHT_LSB = 8;
  localparam int unsigned CNT_MSB    = 7;
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned WEIGHT_W   = WEIGHT_MSB - WEIGHT_LSB + 1;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RESP     = 3'd3
`ifdef WRR_CFG_VERIFY_EN
    ,
    ST_VFY_ISSUE = 3'd4,
    ST_VFY_WAIT  = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/wrr_cfg_master.sv
// Host-to-rank-calculator config master: one outstanding weight write or readback at a time.
// Optional write read-back verification is compiled in with WRR_CFG_VERIFY_EN.
module wrr_cfg_master
  import wrr_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned IDX_W       = 8
) (
  input  logic               clk_cp,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [IDX_W-1:0]   req_index,
  input  logic [WDATA_W-1:0] req_wdata,
  output logic               wire_out_cpu_valid,
  output logic               wire_out_cpu_write_sig,
  output logic               wire_out_cpu_read_sig,
  output logic [IDX_W-1:0]   wire_out_cpu_index,
  output logic [WDATA_W-1:0] wire_out_cpu_config_write,
  input  logic               wire_in_cpu_valid,
  input  logic [IDX_W-1:0]   wire_in_cpu_index,
  input  logic [RDBK_W-1:0]  wire_in_cpu_val,
  output logic               rsp_valid,
  output logic [RDBK_W-1:0]  rsp_data,
  output logic [IDX_W-1:0]   rsp_index,
  output logic [1:0]         rsp_err
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic                r_write;
  logic [IDX_W-1:0]    r_index;
  logic [WDATA_W-1:0]  r_wdata;

  logic                w_accept, w_match, w_timeout;
  logic                w_req_ready_n, w_cpu_valid_n, w_cpu_write_n, w_cpu_read_n;
  logic                w_rsp_valid_n;
  logic [RDBK_W-1:0]   w_rsp_data_n;
  logic [1:0]          w_rsp_err_n;

  assign w_accept  = req_valid & req_ready;
  assign w_match   = wire_in_cpu_valid & (wire_in_cpu_index == r_index);
  assign w_timeout = (r_cnt == CNT_LAST);

  assign wire_out_cpu_index        = r_index;
  assign wire_out_cpu_config_write = r_wdata;
  assign rsp_index                 = r_index;

  always_ff @(posedge clk_cp or negedge rst) begin : p_state
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next state, timeout counter and the next value of every registered output
  always_comb begin : p_next
    w_state_n     = r_state;
    w_cnt_n       = '0;
    w_rsp_data_n  = '0;
    w_rsp_err_n   = ERR_OK;
    w_cpu_valid_n = 1'b0;
    w_cpu_write_n = 1'b0;
    w_cpu_read_n  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (r_write) begin
`ifdef WRR_CFG_VERIFY_EN
          w_state_n = ST_VFY_ISSUE;
`else
          w_state_n = ST_RESP;
`endif
        end else begin
          w_state_n = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (w_match) begin
          w_state_n    = ST_RESP;
          w_rsp_data_n = wire_in_cpu_val;
        end else if (w_timeout) begin
          w_state_n   = ST_RESP;
          w_rsp_err_n = ERR_TIMEOUT;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_n = ST_IDLE;
      end
`ifdef WRR_CFG_VERIFY_EN
      ST_VFY_ISSUE: begin
        w_state_n = ST_VFY_WAIT;
      end
      ST_VFY_WAIT: begin
        if (w_match) begin
          w_state_n    = ST_RESP;
          w_rsp_data_n = wire_in_cpu_val;
          if (wire_in_cpu_val[WEIGHT_MSB:WEIGHT_LSB] != r_wdata[WEIGHT_W-1:0])
            w_rsp_err_n = ERR_VERIFY;
        end else if (w_timeout) begin
          w_state_n   = ST_RESP;
          w_rsp_err_n = ERR_TIMEOUT;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
`endif
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // Command strobes are issued on entry to an issue state
    if (w_state_n == ST_ISSUE) begin
      w_cpu_valid_n = 1'b1;
      w_cpu_write_n = req_write;
      w_cpu_read_n  = ~req_write;
    end
`ifdef WRR_CFG_VERIFY_EN
    if (w_state_n == ST_VFY_ISSUE) begin
      w_cpu_valid_n = 1'b1;
      w_cpu_read_n  = 1'b1;
    end
`endif
    w_req_ready_n = (w_state_n == ST_IDLE);
    w_rsp_valid_n = (w_state_n == ST_RESP);
  end

  always_ff @(posedge clk_cp or negedge rst) begin : p_txn
    if (!rst) begin
      r_write <= 1'b0;
      r_index <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_index <= req_index;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk_cp or negedge rst) begin : p_out
    if (!rst) begin
      req_ready              <= 1'b0;
      wire_out_cpu_valid     <= 1'b0;
      wire_out_cpu_write_sig <= 1'b0;
      wire_out_cpu_read_sig  <= 1'b0;
      rsp_valid              <= 1'b0;
      rsp_data               <= '0;
      rsp_err                <= ERR_OK;
    end else begin
      req_ready              <= w_req_ready_n;
      wire_out_cpu_valid     <= w_cpu_valid_n;
      wire_out_cpu_write_sig <= w_cpu_write_n;
      wire_out_cpu_read_sig  <= w_cpu_read_n;
      rsp_valid              <= w_rsp_valid_n;
      rsp_data               <= w_rsp_data_n;
      rsp_err                <= w_rsp_err_n;
    end
  end

endmodule

// File: tb/tb_wrr_cfg_master.sv
// Scoreboard bench for wrr_cfg_master: directed cases plus random traffic against a
// transaction-level reference model. Honors WRR_CFG_VERIFY_EN like the design.
module tb_wrr_cfg_master;

  localparam int T     = 16;
  localparam int IDX_W = 8;
`ifdef WRR_CFG_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic              clk_cp = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write;
  logic [IDX_W-1:0]  req_index;
  logic [8:0]        req_wdata;
  logic              wire_out_cpu_valid, wire_out_cpu_write_sig, wire_out_cpu_read_sig;
  logic [IDX_W-1:0]  wire_out_cpu_index;
  logic [8:0]        wire_out_cpu_config_write;
  logic              wire_in_cpu_valid;
  logic [IDX_W-1:0]  wire_in_cpu_index;
  logic [26:0]       wire_in_cpu_val;
  logic              rsp_valid;
  logic [26:0]       rsp_data;
  logic [IDX_W-1:0]  rsp_index;
  logic [1:0]        rsp_err;

  wrr_cfg_master #(.TIMEOUT_CYC(T), .IDX_W(IDX_W)) dut (
    .clk_cp(clk_cp), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_index(req_index), .req_wdata(req_wdata),
    .wire_out_cpu_valid(wire_out_cpu_valid), .wire_out_cpu_write_sig(wire_out_cpu_write_sig),
    .wire_out_cpu_read_sig(wire_out_cpu_read_sig), .wire_out_cpu_index(wire_out_cpu_index),
    .wire_out_cpu_config_write(wire_out_cpu_config_write),
    .wire_in_cpu_valid(wire_in_cpu_valid), .wire_in_cpu_index(wire_in_cpu_index),
    .wire_in_cpu_val(wire_in_cpu_val),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_index(rsp_index), .rsp_err(rsp_err)
  );

  always #5 clk_cp = ~clk_cp;

  int cyc = 0;
  always @(posedge clk_cp) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [26:0]      data;
    logic [1:0]       err;
    logic [IDX_W-1:0] idx;
  } rsp_t;

  typedef struct {
    int               cyc;
    logic             wr;
    logic             rd;
    logic [IDX_W-1:0] idx;
    logic [8:0]       cfg;
  } cmd_t;

  rsp_t exp_rsp[$];
  cmd_t exp_cmd[$];
  int checks   = 0;
  int failures = 0;

  // Response schedule for the current transaction (cycle offsets after acceptance)
  int               r_n;
  int               r_off [2];
  logic [IDX_W-1:0] r_idx [2];
  logic [26:0]      r_val [2];

  // Monitor: compares every command strobe and every response against the queues
  always @(negedge clk_cp) begin
    if (wire_out_cpu_valid) begin
      checks++;
      if (exp_cmd.size() == 0) begin
        failures++;
        $display("FAIL cmd_unexpected cyc=%0d got wr=%b rd=%b idx=%h", cyc,
                 wire_out_cpu_write_sig, wire_out_cpu_read_sig, wire_out_cpu_index);
      end else begin
        cmd_t c;
        c = exp_cmd.pop_front();
        if (cyc != c.cyc || wire_out_cpu_write_sig !== c.wr || wire_out_cpu_read_sig !== c.rd ||
            wire_out_cpu_index !== c.idx || wire_out_cpu_config_write !== c.cfg) begin
          failures++;
          $display("FAIL cmd got cyc=%0d wr=%b rd=%b idx=%h cfg=%h want cyc=%0d wr=%b rd=%b idx=%h cfg=%h",
                   cyc, wire_out_cpu_write_sig, wire_out_cpu_read_sig, wire_out_cpu_index,
                   wire_out_cpu_config_write, c.cyc, c.wr, c.rd, c.idx, c.cfg);
        end
      end
    end
    if (rsp_valid) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected cyc=%0d got data=%h err=%b", cyc, rsp_data, rsp_err);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        if (cyc != e.cyc || rsp_data !== e.data || rsp_err !== e.err || rsp_index !== e.idx) begin
          failures++;
          $display("FAIL rsp got cyc=%0d data=%h err=%b idx=%h want cyc=%0d data=%h err=%b idx=%h",
                   cyc, rsp_data, rsp_err, rsp_index, e.cyc, e.data, e.err, e.idx);
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {27'(0), rsp_valid, rsp_err, rsp_index, wire_out_cpu_valid, wire_out_cpu_write_sig,
            wire_out_cpu_read_sig, wire_out_cpu_index, wire_out_cpu_config_write, req_ready};
  endfunction

  // Offer a request; returns the cycle in which it is accepted and queues its command strobes
  task automatic issue_req(input logic w, input logic [IDX_W-1:0] idx, input logic [8:0] wd,
                           output int acc);
    int guard;
    @(negedge clk_cp);
    req_valid = 1'b1; req_write = w; req_index = idx; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk_cp);
      guard++;
    end
    acc = cyc;
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout got=0 want=1");
    end
    exp_cmd.push_back('{cyc: acc + 1, wr: w, rd: ~w, idx: idx, cfg: wd});
    if (w && VFY) exp_cmd.push_back('{cyc: acc + 2, wr: 1'b0, rd: 1'b1, idx: idx, cfg: wd});
  endtask

  // Reference model: first in-window response with the right index wins, else timeout
  function automatic rsp_t model(input logic w, input logic [IDX_W-1:0] idx, input logic [8:0] wd,
                                 input int acc);
    rsp_t e;
    int base;
    e.idx = idx; e.data = '0; e.err = 2'b00;
    if (w && !VFY) begin
      e.cyc = acc + 2;
      return e;
    end
    base  = w ? acc + 3 : acc + 2;
    e.cyc = base + T;
    e.err = 2'b01;
    for (int i = 0; i < r_n; i++) begin
      int rc;
      rc = acc + r_off[i];
      if (r_idx[i] == idx && rc >= base && rc <= base + T - 1) begin
        e.cyc  = rc + 1;
        e.data = r_val[i];
        e.err  = (w && r_val[i][15:8] != wd[7:0]) ? 2'b10 : 2'b00;
        return e;
      end
    end
    return e;
  endfunction

  // Full transaction: request, responder playback, then confirm the response was seen
  task automatic do_txn(input logic w, input logic [IDX_W-1:0] idx, input logic [8:0] wd);
    int acc;
    issue_req(w, idx, wd, acc);
    exp_rsp.push_back(model(w, idx, wd, acc));
    for (int c = 1; c <= T + 6; c++) begin
      @(negedge clk_cp);
      if (c == 1) req_valid = 1'b0;
      wire_in_cpu_valid = 1'b0;
      for (int i = 0; i < r_n; i++) begin
        if (r_off[i] == c) begin
          wire_in_cpu_valid = 1'b1;
          wire_in_cpu_index = r_idx[i];
          wire_in_cpu_val   = r_val[i];
        end
      end
    end
    @(negedge clk_cp);
    wire_in_cpu_valid = 1'b0;
    checks++;
    if (exp_rsp.size() != 0 || exp_cmd.size() != 0) begin
      failures++;
      $display("FAIL txn_drain got pending rsp=%0d cmd=%0d want 0", exp_rsp.size(), exp_cmd.size());
      exp_rsp.delete();
      exp_cmd.delete();
    end
    r_n = 0;
  endtask

  task automatic sched(input int n, input int o0, input logic [IDX_W-1:0] i0, input logic [26:0] v0,
                       input int o1, input logic [IDX_W-1:0] i1, input logic [26:0] v1);
    r_n = n;
    r_off[0] = o0; r_idx[0] = i0; r_val[0] = v0;
    r_off[1] = o1; r_idx[1] = i1; r_val[1] = v1;
  endtask

  initial begin
    int acc;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_index = '0; req_wdata = '0;
    wire_in_cpu_valid = 1'b0; wire_in_cpu_index = '0; wire_in_cpu_val = '0; r_n = 0;

    repeat (3) @(negedge clk_cp);
    check_eq("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    @(negedge clk_cp);
    check_eq("ready_after_reset", 64'(req_ready), 64'd1);

    // Plain write; stray response during it must be ignored
    sched(1, 1, 8'h00, 27'h0000500, 0, 8'h00, 27'h0);
    do_txn(1'b1, 8'h00, 9'd5);
    // Read answered 4 cycles after acceptance
    sched(1, 4, 8'h22, {11'd3, 8'd2, 8'd1}, 0, 8'h00, 27'h0);
    do_txn(1'b0, 8'h22, 9'd0);
    // Silent responder: timeout
    sched(0, 0, 8'h00, 27'h0, 0, 8'h00, 27'h0);
    do_txn(1'b0, 8'h01, 9'd0);
    // Wrong index ignored, right index taken
    sched(2, 3, 8'h02, 27'h1234567, 5, 8'h01, 27'h7654321);
    do_txn(1'b0, 8'h01, 9'd0);
    // Match on the last window cycle beats timeout
    sched(1, T + 1, 8'h33, 27'h00abcde, 0, 8'h00, 27'h0);
    do_txn(1'b0, 8'h33, 9'd0);
    // Match one cycle too late, and one during ISSUE: both lost to timeout
    sched(2, 1, 8'h44, 27'h1111111, T + 2, 8'h44, 27'h2222222);
    do_txn(1'b0, 8'h44, 9'd0);
`ifdef WRR_CFG_VERIFY_EN
    sched(1, 4, 8'h21, {11'd7, 8'd3, 8'd9}, 0, 8'h00, 27'h0);
    do_txn(1'b1, 8'h21, 9'd3);
    sched(1, 4, 8'h21, {11'd7, 8'd4, 8'd9}, 0, 8'h00, 27'h0);
    do_txn(1'b1, 8'h21, 9'd3);
    sched(0, 0, 8'h00, 27'h0, 0, 8'h00, 27'h0);
    do_txn(1'b1, 8'h21, 9'd3);
`endif

    // Reset during WAIT_RSP aborts; late response after reset is discarded
    issue_req(1'b0, 8'h55, 9'd0, acc);
    @(negedge clk_cp);
    req_valid = 1'b0;
    repeat (3) @(negedge clk_cp);
    #2;
    rst = 1'b0;
    exp_rsp.delete();
    exp_cmd.delete();
    #1;
    check_eq("abort_outputs", all_outs(), 64'd0);
    @(negedge clk_cp);
    wire_in_cpu_valid = 1'b1; wire_in_cpu_index = 8'h55; wire_in_cpu_val = 27'h5555555;
    @(negedge clk_cp);
    rst = 1'b1;
    @(negedge clk_cp);
    wire_in_cpu_valid = 1'b0;
    check_eq("ready_after_abort", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk_cp);
    check_eq("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
    sched(1, 2, 8'h56, 27'h0102030, 0, 8'h00, 27'h0);
    do_txn(1'b0, 8'h56, 9'd0);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      logic             w;
      logic [IDX_W-1:0] idx;
      logic [8:0]       wd;
      w   = 1'($urandom_range(0, 1));
      idx = 8'($urandom);
      wd  = 9'($urandom);
      r_n = $urandom_range(0, 2);
      r_off[0] = $urandom_range(1, T + 3);
      r_off[1] = r_off[0] + $urandom_range(1, 4);
      for (int i = 0; i < 2; i++) begin
        r_idx[i] = ($urandom_range(0, 2) != 0) ? idx : (idx ^ 8'($urandom_range(1, 255)));
        r_val[i] = 27'($urandom);
        if ($urandom_range(0, 1) == 1) r_val[i][15:8] = wd[7:0];
      end
      do_txn(w, idx, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
